uart_rx_cfg: RTL and testbench

Parametrised UART receiver: configurable data width, parity and stop-bit count, with framing/parity error detection and a valid/ready output handshake. Sits between the serial pin and the byte-stream consumer (command decoder or RX FIFO); replaces the fixed 8N1 receiver in new designs. Holds one received frame while the consumer stalls and flags overrun instead of silently overwriting.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx_cfg.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and a
// parity helper. Used by the receiver and intended for the transmitter too.
package uart_pkg;

    // Widest data field any UART instance may use.
    localparam int MAX_DATA_BITS = 9;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // XOR of all data bits; narrower frames pass their data zero-extended.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial line front end: two-flop synchroniser (idle-high reset) and, when
// UART_RX_MAJORITY_EN is defined, a 2-of-3 majority vote over the current and
// two preceding synchronised values. rx_s feeds start detection, rx_bit feeds
// every centre sample.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic rx_serial,
    output logic rx_s,
    output logic rx_bit
);

    logic sync_q;

    // Synchronise the asynchronous line; both stages reset to the idle level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so both stages sample the old values.
            sync_q <= rx_serial;
            rx_s   <= sync_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Keep the two previous synchronised values for the majority vote.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign rx_bit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with parity/framing error detection, a one-frame
// output register with valid/ready handshake and overrun flagging.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx_serial,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] IDX_DATA  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_STOP  = IW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_MODE == PARITY_ODD);

    logic rx_s;
    logic rx_bit;

    uart_rx_sampler u_sampler (
        .clock     (i_clock),
        .reset     (i_reset),
        .rx_serial (i_rx_serial),
        .rx_s      (rx_s),
        .rx_bit    (rx_bit)
    );

    uart_state_e            state_q, state_next;
    logic [CW-1:0]          cnt_q, cnt_next;
    logic [IW-1:0]          idx_q, idx_next;
    logic [DATA_BITS-1:0]   shift_q, shift_next;
    logic                   perr_q, perr_next;
    logic                   ferr_q, ferr_next;
    logic                   complete;
    logic [MAX_DATA_BITS-1:0] shift_ext;

    assign shift_ext = MAX_DATA_BITS'(shift_q);

    // Frame state and receive datapath registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            idx_q   <= idx_next;
            shift_q <= shift_next;
            perr_q  <= perr_next;
            ferr_q  <= ferr_next;
        end
    end

    // Next-state logic: bit timing, centre sampling and error accumulation.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state_q;
        cnt_next   = cnt_q;
        idx_next   = idx_q;
        shift_next = shift_q;
        perr_next  = perr_q;
        ferr_next  = ferr_q;
        complete   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (!rx_s) state_next = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_next   = '0;
                    perr_next  = 1'b0;
                    ferr_next  = 1'b0;
                    state_next = rx_bit ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_next   = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_next = {rx_bit, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_DATA) begin
                        idx_next   = '0;
                        state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_next = idx_q + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_next   = '0;
                    perr_next  = (calc_parity(shift_ext) ^ rx_bit) != PAR_ODD;
                    state_next = ST_STOP;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_next = '0;
                    if (!rx_bit) ferr_next = 1'b1;
                    if (idx_q == IDX_STOP) begin
                        // Straight back to IDLE so an immediate start bit is caught.
                        idx_next   = '0;
                        complete   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_q + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output holding register: load on completion when free or being drained,
    // flag overrun when stalled, clear valid and flags on acceptance.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_rx_valid   <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (complete) begin
            if (!o_rx_valid || i_rx_ready) begin
                o_rx_valid   <= 1'b1;
                o_rx_data    <= shift_next;
                o_parity_err <= perr_next;
                o_frame_err  <= ferr_next;
                o_overrun    <= 1'b0;
            end else begin
                o_overrun <= 1'b1;
            end
        end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, both at
// 16 clocks per bit. Expected frames are queued when sent and compared when
// each instance hands a frame over. Majority-vote stimulus runs only when
// UART_RX_MAJORITY_EN is defined.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, ready_a, valid_a, perr_a, ferr_a, ovr_a;
    logic [7:0] data_a;
    logic       rx_b, ready_b, valid_b, perr_b, ferr_b, ovr_b;
    logic [6:0] data_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_a = 0;
    int   hs_b = 0;
    int   pushed_a = 0;
    int   pushed_b = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_rx_serial(rx_a),
        .o_rx_valid(valid_a), .i_rx_ready(ready_a), .o_rx_data(data_a),
        .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_overrun(ovr_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_rx_serial(rx_b),
        .o_rx_valid(valid_b), .i_rx_ready(ready_b), .o_rx_data(data_b),
        .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_overrun(ovr_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [8:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
        q_a.push_back(e);
        pushed_a++;
    endtask

    task automatic push_b(input logic [8:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
        q_b.push_back(e);
        pushed_b++;
    endtask

    // Scoreboard: a handshake at the coming edge consumes one expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_a && ready_a) begin
            hs_a++;
            if (q_a.size() == 0) begin
                check("spurious_valid_a", 16'(valid_a), 16'd0);
            end else begin
                e = q_a.pop_front();
                check("data_a", 16'(data_a), 16'(e.data));
                check("perr_a", 16'(perr_a), 16'(e.perr));
                check("ferr_a", 16'(ferr_a), 16'(e.ferr));
                check("ovr_a",  16'(ovr_a),  16'(e.ovr));
            end
        end
        if (!rst && valid_b && ready_b) begin
            hs_b++;
            if (q_b.size() == 0) begin
                check("spurious_valid_b", 16'(valid_b), 16'd0);
            end else begin
                e = q_b.pop_front();
                check("data_b", 16'(data_b), 16'(e.data));
                check("perr_b", 16'(perr_b), 16'(e.perr));
                check("ferr_b", 16'(ferr_b), 16'(e.ferr));
                check("ovr_b",  16'(ovr_b),  16'(e.ovr));
            end
        end
    end

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame, LSB first. stop_lvl[s] is the level of stop bit s. With
    // pulse_ready, ready_a is high only at the completion edge, which falls 11
    // clocks into the last stop bit (2 sync + 1 detect + 8 to centre).
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int pmode, input logic bad_par,
                              input logic [1:0] stop_lvl, input int nstop,
                              input bit pulse_ready);
        logic p;
        set_line(sel, 1'b0);
        idle(CPB);
        for (int i = 0; i < nbits; i++) begin
            set_line(sel, data[i]);
            idle(CPB);
        end
        if (pmode != 0) begin
            p = (^data) ^ (pmode == 1);
            set_line(sel, p ^ bad_par);
            idle(CPB);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(sel, stop_lvl[s]);
            if (pulse_ready && s == nstop - 1) begin
                idle(10);
                ready_a = 1'b1;
                idle(1);
                ready_a = 1'b0;
                idle(5);
            end else begin
                idle(CPB);
            end
        end
        set_line(sel, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 16'(q_a.size() + q_b.size()), 16'd0);
    endtask

    initial begin
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(3);
        check("reset_valid_a", 16'(valid_a), 16'd0);
        check("reset_data_a",  16'(data_a),  16'd0);
        check("reset_perr_a",  16'(perr_a),  16'd0);
        check("reset_ferr_a",  16'(ferr_a),  16'd0);
        check("reset_ovr_a",   16'(ovr_a),   16'd0);
        check("reset_valid_b", 16'(valid_b), 16'd0);

        // 8N1 clean byte: exactly one handshake.
        ready_a = 1'b1;
        push_a(9'h0A5, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(20);
        wait_drain("drain_a5");
        check("a5_single_pulse", 16'(hs_a), 16'd1);
        check("a5_valid_low", 16'(valid_a), 16'd0);

        // 8N1 with stop bit low.
        push_a(9'h03C, 1'b0, 1'b1, 1'b0);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b00, 1, 1'b0);
        idle(40);
        wait_drain("drain_3c");

        // 7E2: wrong parity, right parity, second stop bit low.
        ready_b = 1'b1;
        push_b(9'h055, 1'b1, 1'b0, 1'b0);
        send_frame(1, 9'h055, 7, 2, 1'b1, 2'b11, 2, 1'b0);
        idle(10);
        push_b(9'h055, 1'b0, 1'b0, 1'b0);
        send_frame(1, 9'h055, 7, 2, 1'b0, 2'b11, 2, 1'b0);
        idle(10);
        push_b(9'h02A, 1'b0, 1'b1, 1'b0);
        send_frame(1, 9'h02A, 7, 2, 1'b0, 2'b01, 2, 1'b0);
        idle(40);
        wait_drain("drain_7e2");

        // Stalled consumer: second frame dropped, overrun flagged.
        ready_a = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(20);
        check("ovr_hold_valid", 16'(valid_a), 16'd1);
        check("ovr_hold_data",  16'(data_a),  16'h11);
        check("ovr_flag",       16'(ovr_a),   16'd1);
        push_a(9'h011, 1'b0, 1'b0, 1'b1);
        ready_a = 1'b1;
        wait_drain("drain_ovr");
        idle(2);
        check("ovr_clear_valid", 16'(valid_a), 16'd0);
        check("ovr_clear_flag",  16'(ovr_a),   16'd0);
        check("ovr_keep_data",   16'(data_a),  16'h11);

        // Held frame accepted in the same cycle a new frame completes.
        ready_a = 1'b0;
        send_frame(0, 9'h044, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(10);
        push_a(9'h044, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h033, 8, 0, 1'b0, 2'b11, 1, 1'b1);
        check("swap_valid", 16'(valid_a), 16'd1);
        check("swap_data",  16'(data_a),  16'h33);
        check("swap_ovr",   16'(ovr_a),   16'd0);
        push_a(9'h033, 1'b0, 1'b0, 1'b0);
        ready_a = 1'b1;
        wait_drain("drain_swap");

        // Short low glitch on an idle line: rejected at the start-bit check.
        rx_a = 1'b0;
        idle(CPB / 4);
        rx_a = 1'b1;
        idle(3 * CPB);
        check("glitch_no_valid", 16'(valid_a), 16'd0);

`ifdef UART_RX_MAJORITY_EN
        // One-clock low pulse landing on the centre sample of data bit 3.
        push_a(9'h0FF, 1'b0, 1'b0, 1'b0);
        rx_a = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_a = 1'b1;
            if (i == 3) begin
                idle(8);
                rx_a = 1'b0;
                idle(1);
                rx_a = 1'b1;
                idle(7);
            end else begin
                idle(CPB);
            end
        end
        rx_a = 1'b1;
        idle(CPB);
        wait_drain("drain_majority");
`endif

        // Reset in the middle of 0x81's data bits abandons that frame.
        rx_a = 1'b0;
        idle(CPB);
        rx_a = 1'b1;
        idle(CPB);
        rx_a = 1'b0;
        idle(CPB + 5);
        rst = 1'b1;
        idle(2);
        check("midreset_valid", 16'(valid_a), 16'd0);
        rx_a = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3 * CPB);
        check("postreset_valid", 16'(valid_a), 16'd0);
        push_a(9'h07E, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h07E, 8, 0, 1'b0, 2'b11, 1, 1'b0);
        idle(20);
        wait_drain("drain_7e");

        check("handshakes_a", 16'(hs_a), 16'(pushed_a));
        check("handshakes_b", 16'(hs_b), 16'(pushed_b));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
